pcileech_bar_initiator: RTL and testbench

PCILEECH_BAR_INITIATOR -- requirements
Module: pcileech_bar_initiator

---
 rtl/pcileech_bar_init_pkg.sv | 46 ++++
 rtl/pcileech_bar_initiator.sv | 220 ++++++++++++++++++++++
 tb/tb_pcileech_bar_initiator.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_bar_init_pkg.sv
// -----------------------------------------------------------------------------
// pcileech_bar_init_pkg
// Shared types and constants for the BAR command initiator: command opcodes,
// response status codes, FSM state encoding, tag/context widths, and small
// helpers for building read contexts and evaluating poll compares.
// -----------------------------------------------------------------------------
package pcileech_bar_init_pkg;

    localparam int TAG_W = 8;
    localparam int CTX_W = 88;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        STAT_OK        = 2'b00,
        STAT_TIMEOUT   = 2'b01,
        STAT_POLL_FAIL = 2'b10,
        STAT_BAD_OP    = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RESP     = 3'd4
    } state_e;

    // Read context carries only the tag in its low byte; upper bits are zero.
    function automatic logic [CTX_W-1:0] make_ctx(input logic [TAG_W-1:0] tag);
        return {{(CTX_W-TAG_W){1'b0}}, tag};
    endfunction

    // Poll succeeds when every bit selected by the mask equals the expected value.
    function automatic logic poll_match(input logic [31:0] rd_data,
                                        input logic [31:0] exp_data,
                                        input logic [31:0] mask);
        return ((rd_data & mask) == (exp_data & mask));
    endfunction

endpackage

// File: rtl/pcileech_bar_initiator.sv
// -----------------------------------------------------------------------------
// pcileech_bar_initiator
// Executes one BAR command at a time (write, read, or poll-until-match) against
// a BAR register responder and returns a single result per command.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only when idle)
//   cmd_op/addr/be/data/mask        opcode, address, byte enables, write data
//                                   or poll expected value, poll mask
//   wr_valid/addr/be/data           one-cycle BAR write strobe
//   rd_req_valid/addr/ctx           one-cycle BAR read request, ctx = tag
//   rd_rsp_valid/ctx/data           read response; only the issued tag counts
//   rsp_valid/ready/data/status     result, held until consumed
//   busy                            high whenever a command is in flight
//
// Every output is a register. A read request is only issued from RD_ISSUE and
// the FSM never leaves RD_WAIT until that read resolves, so at most one read is
// ever outstanding.
// -----------------------------------------------------------------------------
module pcileech_bar_initiator
    import pcileech_bar_init_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int POLL_MAX       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_addr,
    input  logic [3:0]        cmd_be,
    input  logic [31:0]       cmd_data,
    input  logic [31:0]       cmd_mask,
    output logic [31:0]       wr_addr,
    output logic [3:0]        wr_be,
    output logic [31:0]       wr_data,
    output logic              wr_valid,
    output logic [CTX_W-1:0]  rd_req_ctx,
    output logic [31:0]       rd_req_addr,
    output logic              rd_req_valid,
    input  logic [CTX_W-1:0]  rd_rsp_ctx,
    input  logic [31:0]       rd_rsp_data,
    input  logic              rd_rsp_valid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_status,
    output logic              busy
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    state_e             state_r;
    op_e                op_r;
    logic [31:0]        addr_r;
    logic [31:0]        data_r;
    logic [31:0]        mask_r;
    logic [TAG_W-1:0]   tag_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [POLL_W-1:0]  poll_cnt_r;

    logic               match_s;
    logic               wait_last_s;
    logic               poll_last_s;
    logic               poll_hit_s;
    logic               unused_ctx_s;

    // rd_req_ctx keeps the issued tag after the strobe drops, so it is the
    // reference for matching responses; anything else (stale, future) is dropped.
    assign match_s      = rd_rsp_valid && (rd_rsp_ctx[TAG_W-1:0] == rd_req_ctx[TAG_W-1:0]);
    assign wait_last_s  = (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign poll_last_s  = ((poll_cnt_r + POLL_W'(1)) == POLL_W'(POLL_MAX));
    assign poll_hit_s   = poll_match(rd_rsp_data, data_r, mask_r);
    assign unused_ctx_s = ^rd_rsp_ctx[CTX_W-1:TAG_W];

    // Command FSM: state, counters, tag and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            op_r         <= OP_WRITE;
            addr_r       <= 32'h0;
            data_r       <= 32'h0;
            mask_r       <= 32'h0;
            tag_r        <= {TAG_W{1'b0}};
            wait_cnt_r   <= {WAIT_W{1'b0}};
            poll_cnt_r   <= {POLL_W{1'b0}};
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            wr_valid     <= 1'b0;
            wr_addr      <= 32'h0;
            wr_be        <= 4'h0;
            wr_data      <= 32'h0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= 32'h0;
            rd_req_ctx   <= {CTX_W{1'b0}};
            rsp_valid    <= 1'b0;
            rsp_data     <= 32'h0;
            rsp_status   <= STAT_OK;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_r       <= op_e'(cmd_op);
                        addr_r     <= cmd_addr;
                        data_r     <= cmd_data;
                        mask_r     <= cmd_mask;
                        poll_cnt_r <= {POLL_W{1'b0}};
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        // Outputs for the next state are loaded here so they are
                        // valid for exactly the cycle that state is occupied.
                        case (op_e'(cmd_op))
                            OP_WRITE: begin
                                state_r  <= S_WRITE;
                                wr_valid <= 1'b1;
                                wr_addr  <= cmd_addr;
                                wr_be    <= cmd_be;
                                wr_data  <= cmd_data;
                            end
                            OP_READ, OP_POLL: begin
                                state_r      <= S_RD_ISSUE;
                                rd_req_valid <= 1'b1;
                                rd_req_addr  <= cmd_addr;
                                rd_req_ctx   <= make_ctx(tag_r);
                            end
                            default: begin
                                state_r    <= S_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_data   <= 32'h0;
                                rsp_status <= STAT_BAD_OP;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                S_WRITE: begin
                    state_r    <= S_RESP;
                    wr_valid   <= 1'b0;
                    wr_addr    <= 32'h0;
                    wr_be      <= 4'h0;
                    wr_data    <= 32'h0;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= 32'h0;
                    rsp_status <= STAT_OK;
                end

                S_RD_ISSUE: begin
                    state_r      <= S_RD_WAIT;
                    rd_req_valid <= 1'b0;
                    tag_r        <= tag_r + TAG_W'(1);
                    wait_cnt_r   <= {WAIT_W{1'b0}};
                end

                S_RD_WAIT: begin
                    // A match is evaluated before the timeout, so a response in
                    // the final wait cycle still completes the read.
                    if (match_s) begin
                        if ((op_r == OP_POLL) && !poll_hit_s) begin
                            if (poll_last_s) begin
                                state_r    <= S_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_data   <= rd_rsp_data;
                                rsp_status <= STAT_POLL_FAIL;
                            end else begin
                                state_r      <= S_RD_ISSUE;
                                poll_cnt_r   <= poll_cnt_r + POLL_W'(1);
                                rd_req_valid <= 1'b1;
                                rd_req_addr  <= addr_r;
                                rd_req_ctx   <= make_ctx(tag_r);
                            end
                        end else begin
                            state_r    <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= rd_rsp_data;
                            rsp_status <= STAT_OK;
                        end
                    end else if (wait_last_s) begin
                        state_r    <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= 32'h0;
                        rsp_status <= STAT_TIMEOUT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state_r    <= S_IDLE;
                        rsp_valid  <= 1'b0;
                        rsp_data   <= 32'h0;
                        rsp_status <= STAT_OK;
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        rsp_valid  <= 1'b1;
                    end
                end

                default: begin
                    state_r      <= S_IDLE;
                    cmd_ready    <= 1'b0;
                    busy         <= 1'b0;
                    wr_valid     <= 1'b0;
                    rd_req_valid <= 1'b0;
                    rsp_valid    <= 1'b0;
                    rsp_data     <= 32'h0;
                    rsp_status   <= STAT_OK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_bar_initiator.sv
// -----------------------------------------------------------------------------
// tb_pcileech_bar_initiator
// Pairs the initiator with a small AHCI BAR responder model (1-cycle read
// latency) and checks a table of directed commands plus hand-written
// sequences for timeout, stale/mismatched tags, terminal-cycle match and reset.
// -----------------------------------------------------------------------------
module tb_pcileech_bar_initiator;
    import pcileech_bar_init_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_addr;
    logic [3:0]       cmd_be;
    logic [31:0]      cmd_data;
    logic [31:0]      cmd_mask;
    logic [31:0]      wr_addr;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             wr_valid;
    logic [CTX_W-1:0] rd_req_ctx;
    logic [31:0]      rd_req_addr;
    logic             rd_req_valid;
    logic [CTX_W-1:0] rd_rsp_ctx;
    logic [31:0]      rd_rsp_data;
    logic             rd_rsp_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_status;
    logic             busy;

    pcileech_bar_initiator #(.TIMEOUT_CYCLES(64), .POLL_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
        .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AHCI BAR responder model ----------------
    logic             resp_en;
    logic             inj_valid;
    logic [CTX_W-1:0] inj_ctx;
    logic [31:0]      inj_data;
    logic [31:0]      ghc_r;
    logic             bar_vld_r;
    logic [CTX_W-1:0] bar_ctx_r;
    logic [31:0]      bar_data_r;

    function automatic logic [31:0] bar_read(input logic [31:0] a, input logic [31:0] ghc);
        case (a)
            32'h000: return 32'hC734FF01;
            32'h004: return ghc;
            32'h00C: return 32'h00000003;
            32'h010: return 32'h00010301;
            32'h128: return 32'h00000000;
            default: return 32'h00000000;
        endcase
    endfunction

    // Responder: register writes and 1-cycle read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghc_r      <= 32'h0;
            bar_vld_r  <= 1'b0;
            bar_ctx_r  <= {CTX_W{1'b0}};
            bar_data_r <= 32'h0;
        end else begin
            bar_vld_r  <= rd_req_valid && resp_en;
            bar_ctx_r  <= rd_req_ctx;
            bar_data_r <= bar_read(rd_req_addr, ghc_r);
            if (wr_valid && (wr_addr == 32'h004)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) ghc_r[8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_rsp_valid = bar_vld_r | inj_valid;
    assign rd_rsp_ctx   = inj_valid ? inj_ctx  : bar_ctx_r;
    assign rd_rsp_data  = inj_valid ? inj_data : bar_data_r;

    // ---------------- pulse monitor ----------------
    int         rd_total;
    int         wr_total;
    logic [7:0] last_tag;
    initial begin
        rd_total = 0;
        wr_total = 0;
        last_tag = 8'h0;
    end
    always @(negedge clk) begin
        if (rd_req_valid) begin
            rd_total = rd_total + 1;
            last_tag = rd_req_ctx[7:0];
        end
        if (wr_valid) wr_total = wr_total + 1;
    end

    // ---------------- checking helpers ----------------
    int n_pass;
    int n_total;
    int rd0;
    int wr0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        else n_pass = n_pass + 1;
    endtask

    // Offer a command; returns at the first negedge after the accepting edge.
    task automatic send(input string name, input logic [1:0] op, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data, input logic [31:0] mask);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk({name, " cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
        rd0 = rd_total;
        wr0 = wr_total;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_data  = data;
        cmd_mask  = mask;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; lat counts negedges since acceptance.
    task automatic wait_rsp(output int lat, output int rd, output int wr);
        int n;
        n = 1;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        #1;
        rd = rd_total - rd0;
        wr = wr_total - wr0;
    endtask

    // Check the result holds while rsp_ready is low, then consume it.
    task automatic finish_rsp(input string name, input logic [1:0] st, input logic [31:0] d);
        @(negedge clk);
        chk({name, " hold valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({name, " hold status"}, {30'h0, rsp_status}, {30'h0, st});
        chk({name, " hold data"}, rsp_data, d);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, " valid dropped"}, {31'h0, rsp_valid}, 32'h0);
        chk({name, " ready again"}, {30'h0, cmd_ready, busy}, 32'h2);
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data, input logic [31:0] mask,
                       input logic [1:0] st, input logic [31:0] d, input int erd,
                       input int ewr, input int elat);
        int lat, rd, wr;
        send(name, op, addr, be, data, mask);
        wait_rsp(lat, rd, wr);
        chk({name, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({name, " status"}, {30'h0, rsp_status}, {30'h0, st});
        chk({name, " data"}, rsp_data, d);
        chk({name, " rd pulses"}, rd, erd);
        chk({name, " wr pulses"}, wr, ewr);
        if (elat > 0) chk({name, " latency"}, lat, elat);
        finish_rsp(name, st, d);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] mask;
        logic [1:0]  st;
        logic [31:0] rdata;
        int          rd;
        int          wr;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, rd, wr;
        logic [7:0] t_b, t_c, t_next, old_tag;

        n_pass = 0;  n_total = 0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_be = 4'h0;
        cmd_data = 32'h0; cmd_mask = 32'h0; rsp_ready = 1'b0;
        resp_en = 1'b1; inj_valid = 1'b0; inj_ctx = {CTX_W{1'b0}}; inj_data = 32'h0;
        rst_n = 1'b0;

        //           op     addr     be    data          mask          st     rdata         rd  wr lat
        vecs[0] = '{2'b00, 32'h004, 4'hF, 32'h80000000, 32'h00000000, 2'b00, 32'h00000000, 0,  1, 2};
        vecs[1] = '{2'b01, 32'h004, 4'h0, 32'h00000000, 32'h00000000, 2'b00, 32'h80000000, 1,  0, 3};
        vecs[2] = '{2'b01, 32'h000, 4'h0, 32'h00000000, 32'h00000000, 2'b00, 32'hC734FF01, 1,  0, 3};
        vecs[3] = '{2'b01, 32'h00C, 4'h0, 32'h00000000, 32'h00000000, 2'b00, 32'h00000003, 1,  0, 3};
        vecs[4] = '{2'b10, 32'h128, 4'h0, 32'h00000003, 32'h0000000F, 2'b10, 32'h00000000, 16, 0, 33};
        vecs[5] = '{2'b10, 32'h010, 4'h0, 32'h00010301, 32'hFFFFFFFF, 2'b00, 32'h00010301, 1,  0, 3};
        vecs[6] = '{2'b00, 32'h004, 4'h1, 32'h123456AA, 32'h00000000, 2'b00, 32'h00000000, 0,  1, 2};
        vecs[7] = '{2'b01, 32'h004, 4'h0, 32'h00000000, 32'h00000000, 2'b00, 32'h800000AA, 1,  0, 3};
        vecs[8] = '{2'b11, 32'h000, 4'h0, 32'h00000000, 32'h00000000, 2'b11, 32'h00000000, 0,  0, 1};
        vecs[9] = '{2'b10, 32'h004, 4'h0, 32'hFFFF00AA, 32'h000000FF, 2'b00, 32'h800000AA, 1,  0, 3};

        // Reset state: every output low, including cmd_ready.
        repeat (3) @(negedge clk);
        chk("reset outputs zero",
            {31'h0, (|{cmd_ready, busy, wr_valid, wr_addr, wr_be, wr_data, rd_req_valid,
                       rd_req_addr, rd_req_ctx, rsp_valid, rsp_data, rsp_status})}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready after release", {31'h0, cmd_ready}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].be, vecs[i].data,
                vecs[i].mask, vecs[i].st, vecs[i].rdata, vecs[i].rd, vecs[i].wr, vecs[i].lat);
        end

        // Disconnected responder: TIMEOUT after 64 wait cycles.
        resp_en = 1'b0;
        run("timeout", 2'b01, 32'h000, 4'h0, 32'h0, 32'h0, 2'b01, 32'h0, 1, 0, 66);
        t_b = last_tag;

        // Late response for the timed-out tag, then tag+1, then the right tag.
        send("tagmix", 2'b01, 32'h00C, 4'h0, 32'h0, 32'h0);
        #1;
        t_c = last_tag;
        t_next = t_b + 8'd1;
        chk("tag increments", {24'h0, t_c}, {24'h0, t_next});
        @(negedge clk);
        inj_valid = 1'b1; inj_ctx = make_ctx(t_b); inj_data = 32'hDEADBEEF;
        @(negedge clk);
        t_next = t_c + 8'd1;
        inj_ctx = make_ctx(t_next); inj_data = 32'h11111111;
        @(negedge clk);
        inj_valid = 1'b0;
        chk("tagmix ignored", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        inj_valid = 1'b1; inj_ctx = make_ctx(t_c); inj_data = 32'h22222222;
        @(negedge clk);
        inj_valid = 1'b0;
        wait_rsp(lat, rd, wr);
        chk("tagmix status", {30'h0, rsp_status}, 32'h0);
        chk("tagmix data", rsp_data, 32'h22222222);
        chk("tagmix single read", rd, 1);
        finish_rsp("tagmix", 2'b00, 32'h22222222);

        resp_en = 1'b1;
        run("after timeout", 2'b01, 32'h00C, 4'h0, 32'h0, 32'h0, 2'b00, 32'h3, 1, 0, 3);

        // Match in the last wait cycle wins over timeout.
        resp_en = 1'b0;
        send("terminal", 2'b01, 32'h000, 4'h0, 32'h0, 32'h0);
        #1;
        t_c = last_tag;
        repeat (64) @(negedge clk);
        inj_valid = 1'b1; inj_ctx = make_ctx(t_c); inj_data = 32'hA5A5A5A5;
        @(negedge clk);
        inj_valid = 1'b0;
        chk("terminal valid", {31'h0, rsp_valid}, 32'h1);
        chk("terminal status", {30'h0, rsp_status}, 32'h0);
        chk("terminal data", rsp_data, 32'hA5A5A5A5);
        finish_rsp("terminal", 2'b00, 32'hA5A5A5A5);

        // Reset during RD_WAIT.
        send("rst", 2'b01, 32'h000, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        old_tag = last_tag;
        rst_n = 1'b0;
        #1;
        chk("rst outputs zero",
            {31'h0, (|{cmd_ready, busy, wr_valid, wr_addr, wr_be, wr_data, rd_req_valid,
                       rd_req_addr, rd_req_ctx, rsp_valid, rsp_data, rsp_status})}, 32'h0);
        @(negedge clk);
        inj_valid = 1'b1; inj_ctx = make_ctx(old_tag); inj_data = 32'hDEADBEEF;
        @(negedge clk);
        inj_valid = 1'b0;
        chk("rst no rsp", {31'h0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst release ready", {29'h0, cmd_ready, busy, rsp_valid}, 32'h4);

        send("post rst", 2'b01, 32'h00C, 4'h0, 32'h0, 32'h0);
        #1;
        chk("post rst tag zero", {24'h0, rd_req_ctx[7:0]}, 32'h0);
        @(negedge clk);
        inj_valid = 1'b1; inj_ctx = make_ctx(old_tag); inj_data = 32'hBAD0BAD0;
        @(negedge clk);
        inj_ctx = make_ctx(8'h00); inj_data = 32'h5A5A5A5A;
        @(negedge clk);
        inj_valid = 1'b0;
        wait_rsp(lat, rd, wr);
        chk("post rst status", {30'h0, rsp_status}, 32'h0);
        chk("post rst data", rsp_data, 32'h5A5A5A5A);
        finish_rsp("post rst", 2'b00, 32'h5A5A5A5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
